fetch_sequencer: RTL
====================

# fetch_sequencer

Program-fetch sequencer sitting directly upstream of the 64x8 program memory. It owns the 6-bit program counter, drives the memory address for a full 8-clock machine cycle, and captures the returned byte into a one-entry instruction buffer. Downstream decode consumes the buffer through a valid/ready handshake. It also accepts jump requests that redirect the PC and flush the buffer.

## Interface
- ADDR_W, 6, PC / memory address width (64 locations)
- DATA_W, 8, instruction byte width
- SAMPLE_PHASE, 3, phase in which memory data is captured (0..7)
- RESET_PC, 0, PC value after reset
- clk  in  1  main clock, posedge active; 8 enabled posedges = 1 machine cycle
- rst  in  1  reset, asynchronous, active-high
- ena  in  1  clock enable; low freezes all state, including the handshake
- mem_addr  out  ADDR_W  address to program memory, equals pc
- mem_rdata  in  DATA_W  combinational read data from program memory
- instr_data  out  DATA_W  buffered instruction byte
- instr_valid  out  1  buffer holds an unconsumed byte
- instr_ready  in  1  decoder accepts instr_data this cycle
- jmp_valid  in  1  jump request strobe
- jmp_addr  in  ADDR_W  jump target
- pc  out  ADDR_W  current program counter
- phase  out  3  machine-cycle phase 0..7

## Operation
- Reset (asynchronous, active-high): pc=RESET_PC, phase=0, instr_valid=0, instr_data=0, jump-pending flag=0, pending target=0. mem_addr=RESET_PC.
- All state changes only on posedge clk with ena=1 and rst=0.
- Phase counter: increments 0→7, wraps 7→0. The only exception is the stall at SAMPLE_PHASE.
- mem_addr = pc, constant for the whole machine cycle.
- Capture, at phase==SAMPLE_PHASE:
  - Buffer free (instr_valid=0, or instr_valid&&instr_ready this cycle): instr_data<=mem_rdata, instr_valid<=1, phase advances.
  - Buffer busy (instr_valid=1, instr_ready=0): stall. Phase holds, nothing captured, pc holds.
- Handshake:
  - Transfer occurs on any enabled edge with instr_valid&&instr_ready.
  - After a transfer, instr_valid<=0 unless a capture happens on the same edge.
  - While valid and not accepted, instr_data and instr_valid stay stable.
  - instr_ready with instr_valid=0 has no effect.
- Jump:
  - jmp_valid on an enabled edge sets pending=1 and target<=jmp_addr.
  - If a jump is already pending, the later request overwrites the target (last wins).
- PC update, at phase==7:
  - If pending, or jmp_valid on this same edge (the same-edge jmp_addr wins): pc<=target, pending<=0, instr_valid<=0 (flush).
  - Otherwise pc<=pc+1, modulo 2^ADDR_W (63→0 wraps).
  - If a transfer and a flush occur on the same edge, the transfer counts and the buffer ends empty.
- A jump requested during a stall stays pending until the next phase 7.
- ena=0: phase, pc, buffer and pending flag all hold. instr_ready and jmp_valid are ignored.
- rst asserted mid-cycle: immediate return to reset values. The pending jump and buffered byte are discarded.

## Timing
- Latency, reset release to first data: first instr_valid=1 after 4 enabled edges (phase 0..3). instr_data = mem[RESET_PC].
- Throughput: one instruction per 8 enabled edges when the decoder accepts within the cycle.
- Data launched at phase 3 of cycle N is mem[pc of cycle N]. pc changes on the phase-7 edge.
- Stall extends the machine cycle by one clock per stalled edge. phase reads SAMPLE_PHASE throughout the stall.
- Jump: the new pc is visible on mem_addr the edge after phase 7. The first byte from the target is valid 4 edges later.
- All outputs are registered or derived directly from registers. No combinational path from inputs to outputs.

## Test plan
- Reset/free run: memory mem[i]=i+0x40, instr_ready=1 held.
  - Required: instr_valid rises after edge 4, data 0x40.
  - Then 0x41, 0x42… every 8 edges.
  - pc wraps 63→0 and the following byte is 0x40.
- Backpressure: instr_ready=0 for 20 edges after first valid.
  - Required: phase stuck at 3, pc unchanged, instr_data stable at 0x40.
  - On release, 0x40 transfers, 0x41 is captured on the same edge, and no byte is lost or duplicated.
- Jump with flush: jmp_valid pulse, jmp_addr=0x2A, at phase 5.
  - Required: the buffered byte is dropped at phase 7 unless accepted that edge.
  - pc=0x2A next edge; next valid byte = mem[0x2A].
- Jump overwrite: jmp_addr=0x10 at phase 1, then jmp_addr=0x20 at phase 7.
  - Required: pc=0x20 and pending cleared.
- ena gating: ena=0 for 10 edges mid-cycle, with instr_ready and jmp_valid toggling.
  - Required: all outputs frozen. On resume, the sequence continues unchanged.
- Async reset at phase 5 with valid data and a jump pending.
  - Required: outputs at reset values immediately, before the next clk edge. The restart sequence matches the first scenario.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program-fetch sequencer with one-entry instruction buffer and jump redirect
module fetch_sequencer #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 8,
  parameter int SAMPLE_PHASE = 3,
  parameter int RESET_PC     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        phase
);

  localparam logic [2:0]        SAMPLE  = 3'(SAMPLE_PHASE);
  localparam logic [2:0]        LAST    = 3'd7;
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  // Jump bookkeeping: a request is remembered until the machine cycle ends.
  logic              pending;
  logic [ADDR_W-1:0] target;

  // Decoded per-edge events and next-state values.
  logic              xfer;
  logic              stall;
  logic              capture;
  logic              at_wrap;
  logic              redirect;
  logic [2:0]        phase_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              pending_nxt;
  logic [ADDR_W-1:0] target_nxt;
  logic              valid_nxt;
  logic [DATA_W-1:0] data_nxt;

  // The address is held for the whole machine cycle simply by being the pc register.
  assign mem_addr = pc;

  // Next-state computation: capture/stall at the sample phase, pc advance or redirect at phase 7.
  always_comb begin
    xfer        = instr_valid & instr_ready;
    // A full buffer that is not draining this edge freezes the machine cycle at the sample phase.
    stall       = (phase == SAMPLE) & instr_valid & ~instr_ready;
    capture     = (phase == SAMPLE) & ~stall;
    at_wrap     = (phase == LAST) & ~stall;
    redirect    = at_wrap & (pending | jmp_valid);

    phase_nxt   = stall ? phase : phase + 3'd1;

    valid_nxt   = instr_valid;
    data_nxt    = instr_data;
    if (xfer) begin
      valid_nxt = 1'b0;
    end
    if (capture) begin
      valid_nxt = 1'b1;
      data_nxt  = mem_rdata;
    end
    // A redirect flushes the buffer; any same-edge transfer has already been counted downstream.
    if (redirect) begin
      valid_nxt = 1'b0;
    end

    pc_nxt      = pc;
    pending_nxt = pending;
    target_nxt  = target;
    // Later requests overwrite the remembered target.
    if (jmp_valid) begin
      pending_nxt = 1'b1;
      target_nxt  = jmp_addr;
    end
    if (at_wrap) begin
      pending_nxt = 1'b0;
      if (redirect) begin
        // A request on the phase-7 edge itself beats the stored target.
        pc_nxt = jmp_valid ? jmp_addr : target;
      end else begin
        pc_nxt = pc + 1'b1;
      end
    end
  end

  // State registers: everything freezes while ena is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= PC_INIT;
      phase       <= 3'd0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      pending     <= 1'b0;
      target      <= '0;
    end else if (ena) begin
      pc          <= pc_nxt;
      phase       <= phase_nxt;
      instr_valid <= valid_nxt;
      instr_data  <= data_nxt;
      pending     <= pending_nxt;
      target      <= target_nxt;
    end
  end

endmodule
